// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
package wb_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DROP_W = 8;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HELD  = 2'd1,
      FORCE = 2'd2
   } state_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus bundle: pipeline source, long-latency source, write port and status.
interface wb_arbiter_if #(
   parameter int unsigned DATA_W = wb_pkg::DATA_W,
   parameter int unsigned ADDR_W = wb_pkg::ADDR_W,
   parameter int unsigned DROP_W = wb_pkg::DROP_W
) ();

   logic              P_VALID;
   logic [ADDR_W-1:0] P_RD;
   logic [DATA_W-1:0] P_DATA;
   logic              L_VALID;
   logic              L_READY;
   logic [ADDR_W-1:0] L_RD;
   logic [DATA_W-1:0] L_DATA;
   logic              WRITE_ENABLE;
   logic [ADDR_W-1:0] WB_ADDRESS;
   logic [DATA_W-1:0] WRITE_DATA;
   logic              PEND_VALID;
   logic [ADDR_W-1:0] PEND_RD;
   logic              STALL_REQ;
   logic [DROP_W-1:0] DROP_CNT;

   modport slave (
      input  P_VALID, P_RD, P_DATA, L_VALID, L_RD, L_DATA,
      output L_READY, WRITE_ENABLE, WB_ADDRESS, WRITE_DATA,
             PEND_VALID, PEND_RD, STALL_REQ, DROP_CNT
   );

   modport master (
      output P_VALID, P_RD, P_DATA, L_VALID, L_RD, L_DATA,
      input  L_READY, WRITE_ENABLE, WB_ADDRESS, WRITE_DATA,
             PEND_VALID, PEND_RD, STALL_REQ, DROP_CNT
   );

endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins, long-latency results
// wait in a one-entry hold buffer with starvation escalation and WAW dropping.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   wb_arbiter_if.slave bus
);

   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

   state_e              state_q, state_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [ADDR_W-1:0]   pend_rd_q, pend_rd_d;
   logic [DATA_W-1:0]   pend_data_q, pend_data_d;
   logic [DROP_W-1:0]   drop_q, drop_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;

   logic pw;
   logic l_ready;
   logic l_acc;
   logic drop_inc;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= EMPTY;
         wait_q      <= '0;
         pend_rd_q   <= '0;
         pend_data_q <= '0;
         drop_q      <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         pend_rd_q   <= pend_rd_d;
         pend_data_q <= pend_data_d;
         drop_q      <= drop_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
      end
   end

   // A pipeline write to x0 is not a write: it neither drives the port nor blocks L.
   always_comb begin
      pw          = bus.P_VALID && (bus.P_RD != '0);
      l_ready     = (state_q == EMPTY) && !RESET;
      l_acc       = bus.L_VALID && l_ready;
      state_d     = state_q;
      wait_d      = wait_q;
      pend_rd_d   = pend_rd_q;
      pend_data_d = pend_data_q;
      drop_inc    = 1'b0;
      we_d        = 1'b0;
      addr_d      = '0;
      data_d      = '0;

      if (pw) begin
         we_d   = 1'b1;
         addr_d = bus.P_RD;
         data_d = bus.P_DATA;
      end

      case (state_q)
         EMPTY: begin
            if (l_acc) begin
               if (pw && (bus.P_RD == bus.L_RD)) begin
                  drop_inc = 1'b1;
               end else if (bus.L_RD != '0) begin
                  state_d     = HELD;
                  wait_d      = '0;
                  pend_rd_d   = bus.L_RD;
                  pend_data_d = bus.L_DATA;
               end
            end
         end
         HELD, FORCE: begin
            if (pw) begin
               if (bus.P_RD == pend_rd_q) begin
                  drop_inc = 1'b1;
                  state_d  = EMPTY;
               end else if (state_q == HELD) begin
                  wait_d = wait_q + WAIT_W'(1);
                  if (wait_d == WAIT_W'(MAX_WAIT)) state_d = FORCE;
               end
            end else begin
               we_d    = 1'b1;
               addr_d  = pend_rd_q;
               data_d  = pend_data_q;
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase

      if (state_d == EMPTY) pend_rd_d = '0;

      drop_d = (drop_inc && (drop_q != '1)) ? drop_q + DROP_W'(1) : drop_q;
   end

   assign bus.L_READY      = l_ready;
   assign bus.WRITE_ENABLE = we_q;
   assign bus.WB_ADDRESS   = addr_q;
   assign bus.WRITE_DATA   = data_q;
   assign bus.PEND_VALID   = (state_q != EMPTY);
   assign bus.PEND_RD      = pend_rd_q;
   assign bus.STALL_REQ    = (state_q == FORCE);
   assign bus.DROP_CNT     = drop_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter with a write-port scoreboard.
module tb_wb_arbiter;

   typedef struct {
      int          cyc;
      logic [4:0]  a;
      logic [31:0] d;
   } exp_t;

   logic CLK = 1'b0;
   logic RESET;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   exp_drop = 0;
   exp_t q[$];

   wb_arbiter_if bus ();

   wb_arbiter #(.MAX_WAIT(4)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus.slave)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic idle();
      bus.P_VALID = 1'b0; bus.P_RD = '0; bus.P_DATA = '0;
      bus.L_VALID = 1'b0; bus.L_RD = '0; bus.L_DATA = '0;
   endtask

   task automatic push(input int due, input logic [4:0] a, input logic [31:0] d);
      exp_t e;
      e.cyc = due; e.a = a; e.d = d;
      q.push_back(e);
   endtask

   task automatic drive_p(input logic [4:0] rd, input logic [31:0] d);
      bus.P_VALID = 1'b1; bus.P_RD = rd; bus.P_DATA = d;
      if (rd != 5'd0) push(cyc + 1, rd, d);
   endtask

   task automatic drive_l(input logic [4:0] rd, input logic [31:0] d);
      bus.L_VALID = 1'b1; bus.L_RD = rd; bus.L_DATA = d;
   endtask

   // Advance one clock and check the write port against the scoreboard.
   task automatic step();
      exp_t e;
      @(posedge CLK);
      #1;
      cyc++;
      if (q.size() > 0 && q[0].cyc == cyc) begin
         e = q.pop_front();
         chk("we", 32'(bus.WRITE_ENABLE), 32'd1);
         chk("addr", 32'(bus.WB_ADDRESS), 32'(e.a));
         chk("data", bus.WRITE_DATA, e.d);
      end else begin
         chk("no_write", 32'(bus.WRITE_ENABLE), 32'd0);
      end
   endtask

   initial begin
      idle();
      RESET = 1'b1;
      step();
      step();
      chk("rst_lready", 32'(bus.L_READY), 32'd0);
      chk("rst_addr", 32'(bus.WB_ADDRESS), 32'd0);
      chk("rst_data", bus.WRITE_DATA, 32'd0);
      chk("rst_pend", 32'(bus.PEND_VALID), 32'd0);
      chk("rst_stall", 32'(bus.STALL_REQ), 32'd0);
      chk("rst_drop", 32'(bus.DROP_CNT), 32'd0);
      RESET = 1'b0;
      #1;
      chk("lready_out_of_rst", 32'(bus.L_READY), 32'd1);

      // P write to x5
      drive_p(5'd5, 32'hAA);
      step();
      idle();
      step();

      // Unblocked L to x7: held, then drained two cycles after accept
      drive_l(5'd7, 32'h1234);
      push(cyc + 2, 5'd7, 32'h1234);
      step();
      idle();
      chk("l_lready_low", 32'(bus.L_READY), 32'd0);
      chk("l_pend_valid", 32'(bus.PEND_VALID), 32'd1);
      chk("l_pend_rd", 32'(bus.PEND_RD), 32'd7);
      step();
      chk("l_lready_back", 32'(bus.L_READY), 32'd1);
      chk("l_pend_clear", 32'(bus.PEND_VALID), 32'd0);

      // Starvation: L x9 blocked by four P writes escalates to FORCE
      drive_l(5'd9, 32'h99);
      step();
      idle();
      for (int i = 3; i <= 6; i++) begin
         drive_p(5'(i), 32'(i * 16));
         step();
         chk(i == 6 ? "stall_after_4" : "stall_before_4", 32'(bus.STALL_REQ), i == 6 ? 32'd1 : 32'd0);
         chk("starve_pend", 32'(bus.PEND_RD), 32'd9);
      end
      idle();
      push(cyc + 1, 5'd9, 32'h99);
      step();
      chk("stall_clear", 32'(bus.STALL_REQ), 32'd0);
      chk("force_drained", 32'(bus.PEND_VALID), 32'd0);

      // WAW drop of held entry
      drive_l(5'd8, 32'h77);
      step();
      idle();
      drive_p(5'd8, 32'h55);
      exp_drop++;
      step();
      idle();
      chk("waw_pend", 32'(bus.PEND_VALID), 32'd0);
      chk("waw_drop", 32'(bus.DROP_CNT), 32'(exp_drop));
      step();

      // Same-cycle WAW drop
      drive_p(5'd12, 32'hC);
      drive_l(5'd12, 32'hD);
      exp_drop++;
      step();
      idle();
      chk("same_drop", 32'(bus.DROP_CNT), 32'(exp_drop));
      chk("same_pend", 32'(bus.PEND_VALID), 32'd0);
      step();

      // P to x0 does not block a held entry
      drive_l(5'd2, 32'h22);
      step();
      idle();
      drive_p(5'd0, 32'hEE);
      push(cyc + 1, 5'd2, 32'h22);
      step();
      idle();
      chk("x0_pend", 32'(bus.PEND_VALID), 32'd0);

      // L to x0 discarded without counting
      drive_l(5'd0, 32'h33);
      step();
      idle();
      chk("l_x0_pend", 32'(bus.PEND_VALID), 32'd0);
      chk("l_x0_drop", 32'(bus.DROP_CNT), 32'(exp_drop));
      step();

      // Reset while holding x10, with a P write already on the port
      drive_l(5'd10, 32'h1010);
      step();
      idle();
      drive_p(5'd13, 32'h13);
      step();
      idle();
      RESET = 1'b1;
      step();
      chk("mid_rst_lready", 32'(bus.L_READY), 32'd0);
      chk("mid_rst_pend", 32'(bus.PEND_VALID), 32'd0);
      chk("mid_rst_pend_rd", 32'(bus.PEND_RD), 32'd0);
      chk("mid_rst_drop", 32'(bus.DROP_CNT), 32'd0);
      chk("mid_rst_stall", 32'(bus.STALL_REQ), 32'd0);
      RESET = 1'b0;
      exp_drop = 0;
      step();
      step();

      // Saturating drop counter
      for (int i = 0; i < 257; i++) begin
         drive_p(5'd1, 32'(i));
         drive_l(5'd1, 32'hFFFF);
         step();
         if (exp_drop < 255) exp_drop++;
      end
      idle();
      chk("drop_sat", 32'(bus.DROP_CNT), 32'd255);
      step();
      chk("drop_sat_model", 32'(bus.DROP_CNT), 32'(exp_drop));

      chk("scoreboard_empty", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
